axis_packet_tx: RTL and testbench
=================================

# axis_packet_tx

Parametrised AXI-Stream packet transmitter with an internal beat buffer. It accepts raw data beats over a valid/ready handshake and frames them into packets whose length is given in bytes. It generates TLAST, TKEEP and TSTRB, attaches per-packet TID/TDEST/TUSER, and drives a fully compliant AXI-Stream master port. It sits between the SHA3 datapath output and the AXIS interconnect, and it also serves as the generic stream source for new blocks.

## Interface

- DATA_WIDTH, 64: TDATA width in bits; multiple of 8. BYTES = DATA_WIDTH/8.
- ID_WIDTH, 8: TID width.
- DEST_WIDTH, 4: TDEST width.
- USER_WIDTH, 2: TUSER width.
- DEPTH, 8: buffer capacity in beats; power of two, ≥2.
- LEN_WIDTH, 16: width of pkt_len in bytes.

- ACLK  in  1  clock; all logic on its rising edge.
- ARESET  in  1  reset; asynchronous, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  input beat; byte 0 = bits [7:0].
- pkt_len  in  LEN_WIDTH  packet length in bytes; sampled on the first beat of a packet only.
- pkt_id  in  ID_WIDTH  packet TID; sampled on the first beat.
- pkt_dest  in  DEST_WIDTH  packet TDEST; sampled on the first beat.
- pkt_user  in  USER_WIDTH  packet TUSER; sampled on the first beat.
- TVALID  out  1  master valid.
- TREADY  in  1  slave ready.
- TDATA  out  DATA_WIDTH  beat data.
- TKEEP  out  BYTES  byte qualifiers.
- TSTRB  out  BYTES  always equal to TKEEP.
- TLAST  out  1  final beat of a packet.
- TID  out  ID_WIDTH  packet id.
- TDEST  out  DEST_WIDTH  packet destination.
- TUSER  out  USER_WIDTH  packet user bits.
- fifo_level  out  $clog2(DEPTH+1)  beats held, including the output register.
- busy  out  1  in_pkt || fifo_level != 0.
- err_zero_len  out  1  one-cycle pulse when a zero-length packet is rejected.

## Operation

- Input FSM has two states: IDLE (next accepted beat is the first beat of a packet) and IN_PKT.
- IDLE, accepted beat:
  - Latch pkt_id, pkt_dest and pkt_user into header registers.
  - Set rem = pkt_len.
  - If pkt_len == 0: do not store the beat, pulse err_zero_len, stay in IDLE.
- Every stored beat:
  - last = (rem ≤ BYTES).
  - keep = all ones if rem ≥ BYTES, else the low rem bits set.
  - Push {data, keep, last, header} into the buffer.
- After each push:
  - If last: go to IDLE.
  - Otherwise: rem -= BYTES and go to (or stay in) IN_PKT.
- In IN_PKT, pkt_len and the pkt_* inputs are ignored.
- Buffer:
  - Circular store of DEPTH beats, read/write pointers wrapping modulo DEPTH.
  - The head beat drives the registered AXIS outputs.
  - Beats leave in the order they were accepted.
- s_ready = (fifo_level < DEPTH).
  - When full, a simultaneous pop does not raise s_ready in the same cycle. There is no combinational TREADY→s_ready path.
- Output handshake:
  - Beat transfers when TVALID && TREADY.
  - TVALID never depends combinationally on TREADY.
  - Once TVALID is high, TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST and TUSER hold until the transfer.
- fifo_level: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Reset values while ARESET is high, taking effect immediately:
  - 0: TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER, fifo_level, busy, err_zero_len, s_ready.
  - FSM = IDLE; pointers = 0.
  - s_ready rises on the first ACLK edge after ARESET deasserts.
- ARESET mid-packet: all buffered beats and partial packet state are discarded. The next accepted beat starts a new packet.

## Timing

- Latency: with the buffer empty, a beat accepted at edge N has TVALID=1 with its data after edge N (visible in cycle N+1).
- Throughput: one beat per cycle sustained when TREADY=1.
- Empty buffer with simultaneous push and pop is impossible; a pop requires TVALID.
- s_ready, err_zero_len and busy are registered or derived only from registered state.
- Packet boundary: the first beat of packet k+1 may be accepted the cycle after the last beat of packet k. Back-to-back packets have no bubble.

## Test plan

- DATA_WIDTH=64, pkt_len=24, pkt_id=0x5A, 3 beats, TREADY=1 → 3 consecutive output beats, TKEEP=0xFF on each, TLAST only on beat 3, TID=0x5A, first TVALID one cycle after first accept.
- pkt_len=13, 2 beats → TKEEP 0xFF then 0x1F, TSTRB equal to TKEEP, TLAST on beat 2; FSM back in IDLE.
- DEPTH=8, TREADY=0, offer 9 beats → 8 accepted, s_ready=0, fifo_level=8, output beat stable throughout. Then TREADY=1 → 8 beats drain in order, s_ready returns the cycle after the first pop, 9th beat accepted.
- pkt_len=0 with s_valid=1 → beat accepted, err_zero_len high for exactly one cycle, no output beat, fifo_level stays 0.
- Two back-to-back packets (len 16, id 1; len 8, id 2), with pkt_id changed to 7 during packet 1's second beat → outputs id 1,1 then 2; no bubble between packets.
- ARESET asserted mid-packet with 3 beats buffered → all outputs 0 immediately, fifo_level=0. After release, new pkt_len=8 packet → single beat with TLAST=1, TKEEP=0xFF.

Source files
------------

// File: rtl/axis_packet_tx_if.sv
// axis_packet_tx_if: input beat port, packet header fields, AXI-Stream master port and status.
// The master modport is the transmitter's view; slave is the source/sink environment's view.
interface axis_packet_tx_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 2,
   parameter int DEPTH      = 8,
   parameter int LEN_WIDTH  = 16
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LW    = $clog2(DEPTH + 1);
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic [LEN_WIDTH-1:0]  pkt_len;
   logic [ID_WIDTH-1:0]   pkt_id;
   logic [DEST_WIDTH-1:0] pkt_dest;
   logic [USER_WIDTH-1:0] pkt_user;
   logic                  TVALID;
   logic                  TREADY;
   logic [DATA_WIDTH-1:0] TDATA;
   logic [BYTES-1:0]      TKEEP;
   logic [BYTES-1:0]      TSTRB;
   logic                  TLAST;
   logic [ID_WIDTH-1:0]   TID;
   logic [DEST_WIDTH-1:0] TDEST;
   logic [USER_WIDTH-1:0] TUSER;
   logic [LW-1:0]         fifo_level;
   logic                  busy;
   logic                  err_zero_len;
   modport master (
      input  s_valid, s_data, pkt_len, pkt_id, pkt_dest, pkt_user, TREADY,
      output s_ready, TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
             fifo_level, busy, err_zero_len
   );
   modport slave (
      output s_valid, s_data, pkt_len, pkt_id, pkt_dest, pkt_user, TREADY,
      input  s_ready, TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
             fifo_level, busy, err_zero_len
   );
endinterface

// File: rtl/axis_packet_tx.sv
// axis_packet_tx: frames raw beats into byte-length packets and buffers them for an AXI-Stream master.
// The buffer head drives the AXIS outputs directly, so TVALID/TDATA depend only on registered state.
module axis_packet_tx #(
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 2,
   parameter int DEPTH      = 8,
   parameter int LEN_WIDTH  = 16
) (
   input logic             ACLK,
   input logic             ARESET,
   axis_packet_tx_if.master bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int PW    = $clog2(DEPTH);
   localparam int LW    = $clog2(DEPTH + 1);
   typedef enum logic {IDLE, IN_PKT} state_t;
   state_t                state, state_next;
   logic [LEN_WIDTH-1:0]  rem, rem_next, cur_rem;
   logic [ID_WIDTH-1:0]   hdr_id, id_next;
   logic [DEST_WIDTH-1:0] hdr_dest, dest_next;
   logic [USER_WIDTH-1:0] hdr_user, user_next;
   logic [DATA_WIDTH-1:0] mem_data [DEPTH];
   logic [BYTES-1:0]      mem_keep [DEPTH];
   logic                  mem_last [DEPTH];
   logic [ID_WIDTH-1:0]   mem_id   [DEPTH];
   logic [DEST_WIDTH-1:0] mem_dest [DEPTH];
   logic [USER_WIDTH-1:0] mem_user [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [LW-1:0]         count, count_next;
   logic                  s_ready_q, err_q;
   logic                  accept, zero_len, push, pop, last;
   logic [BYTES-1:0]      keep;
   always_comb begin
      state_next = state;
      rem_next   = rem;
      id_next    = hdr_id;
      dest_next  = hdr_dest;
      user_next  = hdr_user;
      accept     = bus.s_valid && s_ready_q;
      cur_rem    = state == IDLE ? bus.pkt_len : rem;
      zero_len   = accept && state == IDLE && bus.pkt_len == '0;
      push       = accept && !zero_len;
      last       = cur_rem <= LEN_WIDTH'(BYTES);
      for (int i = 0; i < BYTES; i++) keep[i] = cur_rem > LEN_WIDTH'(i);
      if (accept && state == IDLE) begin
         id_next   = bus.pkt_id;
         dest_next = bus.pkt_dest;
         user_next = bus.pkt_user;
      end
      if (push) begin
         state_next = last ? IDLE : IN_PKT;
         rem_next   = cur_rem - LEN_WIDTH'(BYTES);
      end
      pop        = count != '0 && bus.TREADY;
      count_next = push && !pop ? count + LW'(1) : !push && pop ? count - LW'(1) : count;
   end
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state     <= IDLE;
         rem       <= '0;
         hdr_id    <= '0;
         hdr_dest  <= '0;
         hdr_user  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         s_ready_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_next;
         rem       <= rem_next;
         hdr_id    <= id_next;
         hdr_dest  <= dest_next;
         hdr_user  <= user_next;
         wr_ptr    <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr    <= pop ? rd_ptr + PW'(1) : rd_ptr;
         count     <= count_next;
         s_ready_q <= count_next < LW'(DEPTH);
         err_q     <= zero_len;
      end
   end
   // Storage is cleared on reset so every AXIS output reads zero while ARESET is high.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_keep[i] <= '0;
            mem_last[i] <= 1'b0;
            mem_id[i]   <= '0;
            mem_dest[i] <= '0;
            mem_user[i] <= '0;
         end
      end else if (push) begin
         mem_data[wr_ptr] <= bus.s_data;
         mem_keep[wr_ptr] <= keep;
         mem_last[wr_ptr] <= last;
         mem_id[wr_ptr]   <= id_next;
         mem_dest[wr_ptr] <= dest_next;
         mem_user[wr_ptr] <= user_next;
      end
   end
   assign bus.TVALID       = count != '0;
   assign bus.TDATA        = mem_data[rd_ptr];
   assign bus.TKEEP        = mem_keep[rd_ptr];
   assign bus.TSTRB        = mem_keep[rd_ptr];
   assign bus.TLAST        = mem_last[rd_ptr];
   assign bus.TID          = mem_id[rd_ptr];
   assign bus.TDEST        = mem_dest[rd_ptr];
   assign bus.TUSER        = mem_user[rd_ptr];
   assign bus.fifo_level   = count;
   assign bus.busy         = state == IN_PKT || count != '0;
   assign bus.s_ready      = s_ready_q;
   assign bus.err_zero_len = err_q;
endmodule

// File: tb/tb_axis_packet_tx.sv
// tb_axis_packet_tx: directed table of single-cycle vectors plus hand-written full-buffer and mid-packet reset sequences.
module tb_axis_packet_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   always #5 clk = ~clk;
   axis_packet_tx_if #(.DATA_WIDTH(64), .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(2), .DEPTH(8), .LEN_WIDTH(16)) bus ();
   axis_packet_tx #(.DATA_WIDTH(64), .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(2), .DEPTH(8), .LEN_WIDTH(16))
      dut (.ACLK(clk), .ARESET(rst), .bus(bus));
   typedef struct {
      logic        valid;
      logic [63:0] data;
      logic [15:0] len;
      logic [7:0]  id;
      logic [3:0]  dest;
      logic [1:0]  user;
      logic        tready;
      logic        e_valid;
      logic [63:0] e_data;
      logic [7:0]  e_keep;
      logic        e_last;
      logic [7:0]  e_id;
      logic [3:0]  e_dest;
      logic [1:0]  e_user;
      logic [3:0]  e_level;
      logic        e_ready;
      logic        e_busy;
      logic        e_err;
   } vec_t;
   vec_t v [11];
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
      else passed++;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic val, input logic [63:0] d, input logic [15:0] len, input logic [7:0] id,
                        input logic [3:0] dest, input logic [1:0] user, input logic tr);
      bus.s_valid  = val;
      bus.s_data   = d;
      bus.pkt_len  = len;
      bus.pkt_id   = id;
      bus.pkt_dest = dest;
      bus.pkt_user = user;
      bus.TREADY   = tr;
   endtask
   function automatic logic [63:0] dv(input int k);
      return 64'hD0D0_0000_0000_0000 | 64'(k);
   endfunction
   function automatic logic [63:0] fv(input int k);
      return 64'hF0F0_0000_0000_0000 | 64'(k);
   endfunction
   task automatic chk_all_zero(input string n);
      chk({n, " tvalid"}, 64'(bus.TVALID), 64'd0);
      chk({n, " tdata"}, bus.TDATA, 64'd0);
      chk({n, " tkeep"}, 64'(bus.TKEEP), 64'd0);
      chk({n, " tstrb"}, 64'(bus.TSTRB), 64'd0);
      chk({n, " tlast"}, 64'(bus.TLAST), 64'd0);
      chk({n, " tid"}, 64'(bus.TID), 64'd0);
      chk({n, " tdest"}, 64'(bus.TDEST), 64'd0);
      chk({n, " tuser"}, 64'(bus.TUSER), 64'd0);
      chk({n, " level"}, 64'(bus.fifo_level), 64'd0);
      chk({n, " busy"}, 64'(bus.busy), 64'd0);
      chk({n, " err"}, 64'(bus.err_zero_len), 64'd0);
      chk({n, " s_ready"}, 64'(bus.s_ready), 64'd0);
   endtask
   initial begin
      drive(1'b0, 64'd0, 16'd0, 8'd0, 4'd0, 2'd0, 1'b0);
      v[0]  = '{1'b1, dv(1), 16'd24, 8'h5A, 4'h3, 2'h1, 1'b1, 1'b1, dv(1), 8'hFF, 1'b0, 8'h5A, 4'h3, 2'h1, 4'd1, 1'b1, 1'b1, 1'b0};
      v[1]  = '{1'b1, dv(2), 16'd0,  8'h11, 4'h0, 2'h0, 1'b1, 1'b1, dv(2), 8'hFF, 1'b0, 8'h5A, 4'h3, 2'h1, 4'd1, 1'b1, 1'b1, 1'b0};
      v[2]  = '{1'b1, dv(3), 16'd0,  8'h11, 4'h0, 2'h0, 1'b1, 1'b1, dv(3), 8'hFF, 1'b1, 8'h5A, 4'h3, 2'h1, 4'd1, 1'b1, 1'b1, 1'b0};
      v[3]  = '{1'b1, dv(4), 16'd13, 8'h22, 4'hC, 2'h2, 1'b1, 1'b1, dv(4), 8'hFF, 1'b0, 8'h22, 4'hC, 2'h2, 4'd1, 1'b1, 1'b1, 1'b0};
      v[4]  = '{1'b1, dv(5), 16'd99, 8'h00, 4'h0, 2'h0, 1'b1, 1'b1, dv(5), 8'h1F, 1'b1, 8'h22, 4'hC, 2'h2, 4'd1, 1'b1, 1'b1, 1'b0};
      v[5]  = '{1'b1, dv(6), 16'd0,  8'h33, 4'hF, 2'h3, 1'b1, 1'b0, 64'd0, 8'h00, 1'b0, 8'h00, 4'h0, 2'h0, 4'd0, 1'b1, 1'b0, 1'b1};
      v[6]  = '{1'b0, 64'd0, 16'd0,  8'h00, 4'h0, 2'h0, 1'b1, 1'b0, 64'd0, 8'h00, 1'b0, 8'h00, 4'h0, 2'h0, 4'd0, 1'b1, 1'b0, 1'b0};
      v[7]  = '{1'b1, dv(7), 16'd16, 8'h01, 4'h5, 2'h0, 1'b1, 1'b1, dv(7), 8'hFF, 1'b0, 8'h01, 4'h5, 2'h0, 4'd1, 1'b1, 1'b1, 1'b0};
      v[8]  = '{1'b1, dv(8), 16'd16, 8'h07, 4'h9, 2'h2, 1'b1, 1'b1, dv(8), 8'hFF, 1'b1, 8'h01, 4'h5, 2'h0, 4'd1, 1'b1, 1'b1, 1'b0};
      v[9]  = '{1'b1, dv(9), 16'd8,  8'h02, 4'hA, 2'h3, 1'b1, 1'b1, dv(9), 8'hFF, 1'b1, 8'h02, 4'hA, 2'h3, 4'd1, 1'b1, 1'b1, 1'b0};
      v[10] = '{1'b0, 64'd0, 16'd0,  8'h00, 4'h0, 2'h0, 1'b1, 1'b0, 64'd0, 8'h00, 1'b0, 8'h00, 4'h0, 2'h0, 4'd0, 1'b1, 1'b0, 1'b0};
      #1;
      chk_all_zero("reset");
      cyc();
      chk("reset held s_ready", 64'(bus.s_ready), 64'd0);
      rst = 1'b0;
      cyc();
      chk("release s_ready", 64'(bus.s_ready), 64'd1);
      for (int i = 0; i < 11; i++) begin
         drive(v[i].valid, v[i].data, v[i].len, v[i].id, v[i].dest, v[i].user, v[i].tready);
         cyc();
         chk($sformatf("v%0d tvalid", i), 64'(bus.TVALID), 64'(v[i].e_valid));
         chk($sformatf("v%0d level", i), 64'(bus.fifo_level), 64'(v[i].e_level));
         chk($sformatf("v%0d s_ready", i), 64'(bus.s_ready), 64'(v[i].e_ready));
         chk($sformatf("v%0d busy", i), 64'(bus.busy), 64'(v[i].e_busy));
         chk($sformatf("v%0d err", i), 64'(bus.err_zero_len), 64'(v[i].e_err));
         if (v[i].e_valid) begin
            chk($sformatf("v%0d tdata", i), bus.TDATA, v[i].e_data);
            chk($sformatf("v%0d tkeep", i), 64'(bus.TKEEP), 64'(v[i].e_keep));
            chk($sformatf("v%0d tstrb", i), 64'(bus.TSTRB), 64'(v[i].e_keep));
            chk($sformatf("v%0d tlast", i), 64'(bus.TLAST), 64'(v[i].e_last));
            chk($sformatf("v%0d tid", i), 64'(bus.TID), 64'(v[i].e_id));
            chk($sformatf("v%0d tdest", i), 64'(bus.TDEST), 64'(v[i].e_dest));
            chk($sformatf("v%0d tuser", i), 64'(bus.TUSER), 64'(v[i].e_user));
         end
      end
      // fill the buffer with TREADY low, then drain in order
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, fv(k), 16'd72, 8'h44, 4'h6, 2'h1, 1'b0);
         cyc();
      end
      chk("full level", 64'(bus.fifo_level), 64'd8);
      chk("full s_ready", 64'(bus.s_ready), 64'd0);
      chk("full busy", 64'(bus.busy), 64'd1);
      drive(1'b1, fv(8), 16'd72, 8'h44, 4'h6, 2'h1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("stall tvalid", 64'(bus.TVALID), 64'd1);
         chk("stall tdata", bus.TDATA, fv(0));
         chk("stall tkeep", 64'(bus.TKEEP), 64'hFF);
         chk("stall tid", 64'(bus.TID), 64'h44);
         chk("stall level", 64'(bus.fifo_level), 64'd8);
         chk("stall s_ready", 64'(bus.s_ready), 64'd0);
      end
      bus.TREADY = 1'b1;
      cyc();
      chk("first pop level", 64'(bus.fifo_level), 64'd7);
      chk("first pop s_ready", 64'(bus.s_ready), 64'd1);
      chk("first pop tdata", bus.TDATA, fv(1));
      cyc();
      chk("ninth accept level", 64'(bus.fifo_level), 64'd7);
      chk("ninth accept tdata", bus.TDATA, fv(2));
      chk("ninth accept tlast", 64'(bus.TLAST), 64'd0);
      bus.s_valid = 1'b0;
      for (int j = 3; j <= 8; j++) begin
         cyc();
         chk($sformatf("drain%0d tdata", j), bus.TDATA, fv(j));
         chk($sformatf("drain%0d tlast", j), 64'(bus.TLAST), 64'(j == 8));
         chk($sformatf("drain%0d level", j), 64'(bus.fifo_level), 64'(9 - j));
      end
      cyc();
      chk("drained tvalid", 64'(bus.TVALID), 64'd0);
      chk("drained busy", 64'(bus.busy), 64'd0);
      // reset in the middle of a buffered packet
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, dv(16 + k), 16'd64, 8'h55, 4'h7, 2'h2, 1'b0);
         cyc();
      end
      chk("pre-reset level", 64'(bus.fifo_level), 64'd3);
      chk("pre-reset busy", 64'(bus.busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk_all_zero("mid reset");
      #2 rst = 1'b0;
      cyc();
      chk("post-reset s_ready", 64'(bus.s_ready), 64'd1);
      chk("post-reset level", 64'(bus.fifo_level), 64'd0);
      drive(1'b1, 64'hCAFE_F00D_1234_5678, 16'd8, 8'h66, 4'h2, 2'h3, 1'b0);
      cyc();
      bus.s_valid = 1'b0;
      chk("new pkt tvalid", 64'(bus.TVALID), 64'd1);
      chk("new pkt tdata", bus.TDATA, 64'hCAFE_F00D_1234_5678);
      chk("new pkt tlast", 64'(bus.TLAST), 64'd1);
      chk("new pkt tkeep", 64'(bus.TKEEP), 64'hFF);
      chk("new pkt tid", 64'(bus.TID), 64'h66);
      chk("new pkt level", 64'(bus.fifo_level), 64'd1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
